proc_wr_sched: RTL and testbench
================================

PROC_WR_SCHED -- requirements
Module: proc_wr_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per line (even, 4..4094).
REQ-002 SHALL have parameter IMG_H, default 480, meaning active lines per frame (even, 2..65534).
REQ-003 SHALL have parameters BASE1 and BASE2, defaults 16'h0000 and 16'h8000, meaning the SDRAM start addresses of the two frame buffers.
REQ-004 SHALL have parameter BURST, default 8'd128, meaning the SDRAM write burst length.
REQ-005 Port: clk  in  1  single clock for all logic.
REQ-006 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-007 Port: start  in  1  level signal that enables capture.
REQ-008 Port: iDVAL  in  1  pixel valid from data capture.
REQ-009 Port: iDATA  in  12  raw Bayer pixel.
REQ-010 Port: iX_Cont, iY_Cont  in  12, 16  pixel column and row.
REQ-011 Port: lb_clken  out  1  line-buffer shift enable.
REQ-012 Port: lb_shiftin  out  12  line-buffer data.
REQ-013 Port: lb_tap_cur, lb_tap_prv  in  12 each  line-buffer taps for row y and row y-1, valid the cycle after lb_clken.
REQ-014 Port group: WR1_DATA, WR2_DATA (out, 16); WR1, WR2 (out, 1); WR1_ADDR, WR2_ADDR, WR1_MAX_ADDR, WR2_MAX_ADDR (out, 16); WR1_LENGTH, WR2_LENGTH (out, 8); WR1_LOAD, WR2_LOAD (out, 1); WR1_CLK, WR2_CLK (out, 1).
REQ-015 Port: frames_done  out  16  completed-frame count.
REQ-016 Port: short_frames  out  8  aborted-frame count.
REQ-017 Port: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, SYNC, LOAD and RUN.
REQ-019 The FSM SHALL transition IDLE->SYNC when start=1.
REQ-020 The FSM SHALL transition SYNC->LOAD on a cycle with iDVAL=1, iX_Cont=0 and iY_Cont=0.
REQ-021 The FSM SHALL always transition LOAD->RUN after exactly 1 cycle.
REQ-022 lb_clken SHALL equal iDVAL in the LOAD and RUN states and SHALL be 0 otherwise; lb_shiftin SHALL equal iDATA combinationally.
REQ-023 In the LOAD state, the block SHALL pulse WRs_LOAD high for exactly one cycle, where s is the side selected by frame parity (even frames use side 1, odd frames use side 2).
REQ-024 The block SHALL register iX_Cont and iY_Cont 1 cycle after lb_clken, aligned with the taps; on the tap-valid cycle, keep delayed copies of lb_tap_cur and lb_tap_prv.
REQ-025 When the aligned x and y are both odd, the block SHALL compute gray = (cur + prv + cur_d + prv_d) >> 2 in 14-bit arithmetic, truncated to 12 bits.
REQ-026 On the next cycle, the block SHALL drive WRs_DATA = {4'b0, gray} and WRs=1 for exactly one cycle; latency is 2 cycles from the iDVAL of the quad-completing pixel to WRs.
REQ-027 The non-selected side SHALL keep WR=0 and its DATA at 0.
REQ-028 The write counter SHALL increment on each WRs; the block SHALL complete the frame when count reaches FRAME_WORDS = (IMG_W/2)*(IMG_H/2).
REQ-029 On frame completion, the block SHALL increment frames_done, toggle parity and clear the count.
REQ-030 After frame completion, the FSM SHALL go RUN->SYNC if start=1 and RUN->IDLE if start=0.
REQ-031 If iX_Cont=0 and iY_Cont=0 with iDVAL=1 occur in RUN before FRAME_WORDS is reached, the block SHALL increment short_frames (saturating at 255), toggle parity, clear the count, and go RUN->LOAD.
REQ-032 Deassertion of start in the middle of a frame SHALL NOT abort the frame.
REQ-033 When iDVAL=0, the block SHALL hold all counters and the pipeline.
REQ-034 frames_done SHALL wrap from 16'hFFFF to 0.
REQ-035 WRs_ADDR SHALL be BASEs, WRs_MAX_ADDR SHALL be BASEs+FRAME_WORDS, WRs_LENGTH SHALL be BURST, and WRs_CLK SHALL be clk.

Reset
REQ-036 On a clk edge with rst_n=0, the FSM SHALL go to IDLE, parity to side 1, and the counts, pipeline registers, frames_done and short_frames SHALL all clear to 0.
REQ-037 During reset, the block SHALL drive WR1, WR2, WR1_LOAD, WR2_LOAD, WR1_DATA, WR2_DATA, lb_clken and busy to 0.
REQ-038 Reset in the middle of a frame SHALL discard the partial frame without incrementing either counter.

Configuration
REQ-039 When the macro PROC_WR_SCHED_STATS_EN is defined, frames_done and short_frames SHALL operate as specified above.
REQ-040 When PROC_WR_SCHED_STATS_EN is undefined, the counter logic SHALL be removed and frames_done and short_frames SHALL be tied to 0; all other behaviour is unchanged.

Verification
REQ-041 Scenario: IMG_W=4, IMG_H=2, start=1, one frame of all pixels=12'd100 -> WR1_LOAD pulses once, WR1 pulses 2 times with data 16'd100, frames_done=1, and the FSM ends in SYNC.
REQ-042 Scenario: a quad with pixels 1, 2, 3, 6 -> WR data 16'd3, exactly 2 cycles after the fourth iDVAL.
REQ-043 Scenario: two consecutive frames -> the first writes only side 1, the second writes only side 2, and WR2_LOAD pulses once at the start of frame 2.
REQ-044 Scenario: a new frame start after 1 of 2 words -> short_frames=1, frames_done=0, and LOAD is on side 2.
REQ-045 Scenario: rst_n=0 for 1 cycle in the middle of a frame -> all outputs are 0, busy=0, and the next frame uses side 1.
REQ-046 Scenario: start dropped during row 1 -> the frame completes with 2 writes, then the FSM goes to IDLE with busy=0.

Source files
------------

// File: rtl/proc_wr_sched.sv
// proc_wr_sched: Bayer-to-gray write scheduler. Averages each 2x2 Bayer quad
// into one 12-bit gray word and streams it into one of two SDRAM frame buffers.
// Consecutive frames alternate between the two buffers.
// Optional macro PROC_WR_SCHED_STATS_EN enables the frames_done/short_frames
// statistics counters. Without the macro both outputs are tied to zero.
module proc_wr_sched #(
    parameter int          IMG_W = 640,
    parameter int          IMG_H = 480,
    parameter logic [15:0] BASE1 = 16'h0000,
    parameter logic [15:0] BASE2 = 16'h8000,
    parameter logic [7:0]  BURST = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic [11:0] iX_Cont,
    input  logic [15:0] iY_Cont,
    output logic        lb_clken,
    output logic [11:0] lb_shiftin,
    input  logic [11:0] lb_tap_cur,
    input  logic [11:0] lb_tap_prv,
    output logic [15:0] WR1_DATA,
    output logic [15:0] WR2_DATA,
    output logic        WR1,
    output logic        WR2,
    output logic [15:0] WR1_ADDR,
    output logic [15:0] WR2_ADDR,
    output logic [15:0] WR1_MAX_ADDR,
    output logic [15:0] WR2_MAX_ADDR,
    output logic [7:0]  WR1_LENGTH,
    output logic [7:0]  WR2_LENGTH,
    output logic        WR1_LOAD,
    output logic        WR2_LOAD,
    output logic        WR1_CLK,
    output logic        WR2_CLK,
    output logic [15:0] frames_done,
    output logic [7:0]  short_frames,
    output logic        busy
);

    localparam int FRAME_WORDS = (IMG_W / 2) * (IMG_H / 2);
    localparam int CNT_W       = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, SYNC, LOAD, RUN} state_t;

    state_t state;
    state_t state_next;

    // parity = 0 selects buffer 1, parity = 1 selects buffer 2
    logic             parity;
    logic [CNT_W-1:0] count;

    logic        tap_vld;
    logic        x_odd_d;
    logic        y_odd_d;
    logic [11:0] cur_d;
    logic [11:0] prv_d;
    logic [13:0] quad_sum;
    logic [11:0] gray;
    logic        quad_done;

    logic        wr_vld;
    logic        wr_side;
    logic [11:0] wr_data;

    logic frame_start;
    logic frame_end;
    logic short_end;

    assign frame_start = iDVAL && (iX_Cont == 12'd0) && (iY_Cont == 16'd0);
    assign frame_end   = wr_vld && (count == CNT_W'(FRAME_WORDS - 1));
    assign short_end   = (state == RUN) && frame_start && !frame_end;

    // Static SDRAM write-port configuration; the port clocks run off clk
    assign WR1_ADDR     = BASE1;
    assign WR2_ADDR     = BASE2;
    assign WR1_MAX_ADDR = BASE1 + 16'(FRAME_WORDS);
    assign WR2_MAX_ADDR = BASE2 + 16'(FRAME_WORDS);
    assign WR1_LENGTH   = BURST;
    assign WR2_LENGTH   = BURST;
    assign WR1_CLK      = clk;
    assign WR2_CLK      = clk;
    assign lb_shiftin   = iDATA;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a finished frame outranks a coincident frame start
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SYNC;
            SYNC: if (frame_start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN: begin
                if (frame_end) begin
                    state_next = start ? SYNC : IDLE;
                end else if (frame_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs, forced low while reset is asserted
    always_comb begin
        busy     = rst_n && (state != IDLE);
        lb_clken = rst_n && iDVAL && ((state == LOAD) || (state == RUN));
        WR1_LOAD = rst_n && (state == LOAD) && !parity;
        WR2_LOAD = rst_n && (state == LOAD) && parity;
    end

    // Quad average from the current and previous column taps
    always_comb begin
        quad_sum  = {2'b00, lb_tap_cur} + {2'b00, lb_tap_prv}
                  + {2'b00, cur_d} + {2'b00, prv_d};
        gray      = 12'(quad_sum >> 2);
        quad_done = tap_vld && x_odd_d && y_odd_d;
    end

    // Tap-aligned pipeline, write pulse and per-frame word counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_vld <= 1'b0;
            x_odd_d <= 1'b0;
            y_odd_d <= 1'b0;
            cur_d   <= 12'd0;
            prv_d   <= 12'd0;
            wr_vld  <= 1'b0;
            wr_side <= 1'b0;
            wr_data <= 12'd0;
            count   <= '0;
            parity  <= 1'b0;
        end else begin
            tap_vld <= lb_clken;
            if (lb_clken) begin
                x_odd_d <= iX_Cont[0];
                y_odd_d <= iY_Cont[0];
            end
            if (tap_vld) begin
                cur_d <= lb_tap_cur;
                prv_d <= lb_tap_prv;
            end
            wr_vld <= quad_done;
            if (quad_done) begin
                wr_data <= gray;
                wr_side <= parity;
            end
            if (frame_end || short_end) begin
                count  <= '0;
                parity <= ~parity;
            end else if (wr_vld) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Write strobes and data steer to the buffer the word was computed for
    always_comb begin
        WR1      = rst_n && wr_vld && !wr_side;
        WR2      = rst_n && wr_vld && wr_side;
        WR1_DATA = WR1 ? {4'b0000, wr_data} : 16'd0;
        WR2_DATA = WR2 ? {4'b0000, wr_data} : 16'd0;
    end

`ifdef PROC_WR_SCHED_STATS_EN
    // Completed-frame counter (wraps) and aborted-frame counter (saturates)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_done  <= 16'd0;
            short_frames <= 8'd0;
        end else begin
            if (frame_end) begin
                frames_done <= frames_done + 16'd1;
            end
            if (short_end && (short_frames != 8'hFF)) begin
                short_frames <= short_frames + 8'd1;
            end
        end
    end
`else
    assign frames_done  = 16'd0;
    assign short_frames = 8'd0;
`endif

endmodule

// File: tb/tb_proc_wr_sched.sv
// tb_proc_wr_sched: scoreboard bench for proc_wr_sched on a 4x2 image.
// Expected writes (side, data, arrival cycle) are queued as pixels are driven
// and popped when the DUT strobes WR1/WR2. Line-buffer taps come from an ideal
// model that reads the current and previous row straight from the test image.
module tb_proc_wr_sched;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        iDVAL;
    logic [11:0] iDATA;
    logic [11:0] iX_Cont;
    logic [15:0] iY_Cont;
    logic        lb_clken;
    logic [11:0] lb_shiftin;
    logic [11:0] lb_tap_cur;
    logic [11:0] lb_tap_prv;
    logic [15:0] WR1_DATA, WR2_DATA;
    logic        WR1, WR2;
    logic [15:0] WR1_ADDR, WR2_ADDR, WR1_MAX_ADDR, WR2_MAX_ADDR;
    logic [7:0]  WR1_LENGTH, WR2_LENGTH;
    logic        WR1_LOAD, WR2_LOAD, WR1_CLK, WR2_CLK;
    logic [15:0] frames_done;
    logic [7:0]  short_frames;
    logic        busy;

    typedef struct {
        logic        side;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [11:0] img [0:IMG_H-1][0:IMG_W-1];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          load1 = 0, load2 = 0, wr1 = 0, wr2 = 0;

    proc_wr_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iDVAL(iDVAL), .iDATA(iDATA),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .lb_clken(lb_clken),
        .lb_shiftin(lb_shiftin), .lb_tap_cur(lb_tap_cur), .lb_tap_prv(lb_tap_prv),
        .WR1_DATA(WR1_DATA), .WR2_DATA(WR2_DATA), .WR1(WR1), .WR2(WR2),
        .WR1_ADDR(WR1_ADDR), .WR2_ADDR(WR2_ADDR),
        .WR1_MAX_ADDR(WR1_MAX_ADDR), .WR2_MAX_ADDR(WR2_MAX_ADDR),
        .WR1_LENGTH(WR1_LENGTH), .WR2_LENGTH(WR2_LENGTH),
        .WR1_LOAD(WR1_LOAD), .WR2_LOAD(WR2_LOAD), .WR1_CLK(WR1_CLK), .WR2_CLK(WR2_CLK),
        .frames_done(frames_done), .short_frames(short_frames), .busy(busy)
    );

    always #5 clk = ~clk;

    // Ideal line buffer: taps for the shifted pixel appear the next cycle
    always @(posedge clk) begin
        if (lb_clken) begin
            lb_tap_cur <= img[iY_Cont[0]][iX_Cont[1:0]];
            lb_tap_prv <= (iY_Cont[0] == 1'b0) ? 12'd0 : img[0][iX_Cont[1:0]];
        end
    end

    function automatic logic [15:0] fd_exp(input int n);
`ifdef PROC_WR_SCHED_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [7:0] sf_exp(input int n);
`ifdef PROC_WR_SCHED_STATS_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    // One clock: scoreboard the negedge sample, then advance past the posedge
    task automatic tick();
        exp_t        e;
        logic [15:0] got, other;
        @(negedge clk);
        if (WR1 || WR2) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("[TB] FAIL unexpected_write cyc=%0d got WR1=%b WR2=%b want no write",
                         cyc, WR1, WR2);
            end else begin
                e     = q.pop_front();
                got   = WR2 ? WR2_DATA : WR1_DATA;
                other = WR2 ? WR1_DATA : WR2_DATA;
                if ((WR1 && WR2) || (WR2 !== e.side) || (got !== e.data) ||
                    (other !== 16'd0) || (cyc !== e.cyc)) begin
                    $display("[TB] FAIL write got side=%b data=%0d other=%0d cyc=%0d want side=%b data=%0d other=0 cyc=%0d",
                             WR2, got, other, cyc, e.side, e.data, e.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
        if (WR1_LOAD) load1++;
        if (WR2_LOAD) load2++;
        if (WR1) wr1++;
        if (WR2) wr2++;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        iDVAL = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        iDVAL = 1'b0;
        tick();
        tick();
        q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    // Drive linear pixel indices first..last; queue a write at each odd/odd pixel
    task automatic send_range(input logic side, input int first, input int last);
        exp_t        e;
        logic [13:0] s;
        int          x, y;
        for (int i = first; i <= last; i++) begin
            x       = i % IMG_W;
            y       = i / IMG_W;
            iDVAL   = 1'b1;
            iX_Cont = 12'(x);
            iY_Cont = 16'(y);
            iDATA   = img[y][x];
            if ((x % 2 == 1) && (y % 2 == 1)) begin
                s = {2'b00, img[y][x]} + {2'b00, img[y-1][x]}
                  + {2'b00, img[y][x-1]} + {2'b00, img[y-1][x-1]};
                e.side = side;
                e.data = {4'b0000, 12'(s >> 2)};
                e.cyc  = cyc + 2;
                q.push_back(e);
            end
            tick();
        end
        iDVAL = 1'b0;
    endtask

    task automatic fill_random();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                img[y][x] = 12'($urandom_range(0, 4095));
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (q.size() != 0) $display("[TB] FAIL %s_pending got %0d queued want 0", name, q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b1;
        iDVAL   = 1'b1;
        iDATA   = 12'd1234;
        iX_Cont = 12'd0;
        iY_Cont = 16'd0;
        tick();
        tick();
        #1;
        n_checks++;
        if ({busy, lb_clken, WR1, WR2, WR1_LOAD, WR2_LOAD} !== 6'b0 ||
            WR1_DATA !== 16'd0 || WR2_DATA !== 16'd0)
            $display("[TB] FAIL reset_outputs got busy=%b clken=%b wr=%b%b load=%b%b d1=%0d d2=%0d want all 0",
                     busy, lb_clken, WR1, WR2, WR1_LOAD, WR2_LOAD, WR1_DATA, WR2_DATA);
        else n_pass++;
        n_checks++;
        if (frames_done !== 16'd0 || short_frames !== 8'd0)
            $display("[TB] FAIL reset_counters got fd=%0d sf=%0d want 0 0", frames_done, short_frames);
        else n_pass++;
        n_checks++;
        if (lb_shiftin !== 12'd1234)
            $display("[TB] FAIL shiftin got %0d want 1234", lb_shiftin);
        else n_pass++;
        n_checks++;
        if (WR1_ADDR !== 16'h0000 || WR2_ADDR !== 16'h8000 || WR1_MAX_ADDR !== 16'h0002 ||
            WR2_MAX_ADDR !== 16'h8002 || WR1_LENGTH !== 8'd128 || WR2_LENGTH !== 8'd128)
            $display("[TB] FAIL config got a=%h/%h max=%h/%h len=%0d/%0d want 0000/8000 0002/8002 128/128",
                     WR1_ADDR, WR2_ADDR, WR1_MAX_ADDR, WR2_MAX_ADDR, WR1_LENGTH, WR2_LENGTH);
        else n_pass++;
        n_checks++;
        if (WR1_CLK !== clk || WR2_CLK !== clk)
            $display("[TB] FAIL wr_clk got %b/%b want %b", WR1_CLK, WR2_CLK, clk);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_frame();
        int l1, l2, w1, w2;
        do_reset();
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                img[y][x] = 12'd100;
        start = 1'b1;
        idle(2);
        l1 = load1; l2 = load2; w1 = wr1; w2 = wr2;
        iDVAL = 1'b1; iX_Cont = 12'd0; iY_Cont = 16'd0; iDATA = img[0][0];
        #1;
        n_checks++;
        if (lb_clken !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL sync_clken got clken=%b busy=%b want 0 1", lb_clken, busy);
        else n_pass++;
        tick();
        iX_Cont = 12'd1; iDATA = img[0][1];
        #1;
        n_checks++;
        if (lb_clken !== 1'b1 || WR1_LOAD !== 1'b1 || WR2_LOAD !== 1'b0)
            $display("[TB] FAIL load_cycle got clken=%b load=%b%b want 1 10", lb_clken, WR1_LOAD, WR2_LOAD);
        else n_pass++;
        tick();
        send_range(1'b0, 2, 7);
        idle(4);
        n_checks++;
        if (load1 - l1 !== 1 || load2 - l2 !== 0 || wr1 - w1 !== 2 || wr2 - w2 !== 0)
            $display("[TB] FAIL single_counts got load=%0d/%0d wr=%0d/%0d want 1/0 2/0",
                     load1 - l1, load2 - l2, wr1 - w1, wr2 - w2);
        else n_pass++;
        n_checks++;
        if (frames_done !== fd_exp(1) || busy !== 1'b1 || WR1_LOAD !== 1'b0 || WR2_LOAD !== 1'b0)
            $display("[TB] FAIL single_end got fd=%0d busy=%b want fd=%0d busy=1 (SYNC)",
                     frames_done, busy, fd_exp(1));
        else n_pass++;
        check_drained("single");
    endtask

    task automatic test_quad_latency();
        do_reset();
        img[0][0] = 12'd1;    img[0][1] = 12'd2;    img[1][0] = 12'd3;    img[1][1] = 12'd6;
        img[0][2] = 12'd4000; img[0][3] = 12'd4095; img[1][2] = 12'd4095; img[1][3] = 12'd4095;
        start = 1'b1;
        idle(2);
        send_range(1'b0, 0, 7);
        idle(4);
        check_drained("quad");
    endtask

    task automatic test_back_to_back();
        int l2, w1, w2;
        do_reset();
        fill_random();
        start = 1'b1;
        idle(2);
        w1 = wr1; w2 = wr2;
        send_range(1'b0, 0, 7);
        idle(4);
        n_checks++;
        if (wr1 - w1 !== 2 || wr2 - w2 !== 0)
            $display("[TB] FAIL b2b_frame1 got wr=%0d/%0d want 2/0", wr1 - w1, wr2 - w2);
        else n_pass++;
        fill_random();
        l2 = load2; w1 = wr1; w2 = wr2;
        send_range(1'b1, 0, 7);
        idle(4);
        n_checks++;
        if (wr1 - w1 !== 0 || wr2 - w2 !== 2 || load2 - l2 !== 1)
            $display("[TB] FAIL b2b_frame2 got wr=%0d/%0d load2=%0d want 0/2 1", wr1 - w1, wr2 - w2, load2 - l2);
        else n_pass++;
        n_checks++;
        if (frames_done !== fd_exp(2))
            $display("[TB] FAIL b2b_frames got %0d want %0d", frames_done, fd_exp(2));
        else n_pass++;
        check_drained("b2b");
    endtask

    task automatic test_short_frame();
        int l1, l2, w2;
        do_reset();
        fill_random();
        start = 1'b1;
        idle(2);
        send_range(1'b0, 0, 5);
        idle(3);
        fill_random();
        l1 = load1; l2 = load2;
        send_range(1'b1, 0, 0);
        idle(2);
        n_checks++;
        if (short_frames !== sf_exp(1) || frames_done !== 16'd0 || load2 - l2 !== 1 || load1 - l1 !== 0)
            $display("[TB] FAIL short_abort got sf=%0d fd=%0d load=%0d/%0d want sf=%0d fd=0 load=0/1",
                     short_frames, frames_done, load1 - l1, load2 - l2, sf_exp(1));
        else n_pass++;
        w2 = wr2;
        send_range(1'b1, 1, 7);
        idle(4);
        n_checks++;
        if (wr2 - w2 !== 2 || frames_done !== fd_exp(1) || short_frames !== sf_exp(1))
            $display("[TB] FAIL short_next got wr2=%0d fd=%0d sf=%0d want 2 %0d %0d",
                     wr2 - w2, frames_done, short_frames, fd_exp(1), sf_exp(1));
        else n_pass++;
        check_drained("short");
    endtask

    task automatic test_reset_mid();
        int l1, w1, w2;
        do_reset();
        fill_random();
        start = 1'b1;
        idle(2);
        send_range(1'b0, 0, 5);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, lb_clken, WR1, WR2, WR1_LOAD, WR2_LOAD} !== 6'b0 ||
            WR1_DATA !== 16'd0 || WR2_DATA !== 16'd0)
            $display("[TB] FAIL midreset_outputs got busy=%b clken=%b wr=%b%b load=%b%b want all 0",
                     busy, lb_clken, WR1, WR2, WR1_LOAD, WR2_LOAD);
        else n_pass++;
        tick();
        q.delete();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (frames_done !== 16'd0 || short_frames !== 8'd0 || WR1 !== 1'b0 || WR2 !== 1'b0)
            $display("[TB] FAIL midreset_after got fd=%0d sf=%0d wr=%b%b want 0 0 00",
                     frames_done, short_frames, WR1, WR2);
        else n_pass++;
        idle(2);
        l1 = load1; w1 = wr1; w2 = wr2;
        send_range(1'b0, 0, 7);
        idle(4);
        n_checks++;
        if (load1 - l1 !== 1 || wr1 - w1 !== 2 || wr2 - w2 !== 0)
            $display("[TB] FAIL midreset_side got load1=%0d wr=%0d/%0d want 1 2/0", load1 - l1, wr1 - w1, wr2 - w2);
        else n_pass++;
        check_drained("midreset");
    endtask

    task automatic test_stop_mid();
        int w1;
        do_reset();
        fill_random();
        start = 1'b1;
        idle(2);
        w1 = wr1;
        send_range(1'b0, 0, 3);
        start = 1'b0;
        send_range(1'b0, 4, 7);
        idle(4);
        n_checks++;
        if (wr1 - w1 !== 2 || busy !== 1'b0 || frames_done !== fd_exp(1))
            $display("[TB] FAIL stop_mid got wr1=%0d busy=%b fd=%0d want 2 0 %0d",
                     wr1 - w1, busy, frames_done, fd_exp(1));
        else n_pass++;
        check_drained("stop");
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        iDVAL   = 1'b0;
        iDATA   = 12'd0;
        iX_Cont = 12'd0;
        iY_Cont = 16'd0;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                img[y][x] = 12'd0;
        test_reset();
        test_single_frame();
        test_quad_latency();
        test_back_to_back();
        test_short_frame();
        test_reset_mid();
        test_stop_mid();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
